inst_fetch_buf: RTL and testbench

//  Instruction-side memory front end directly downstream of the core's fetch stage.

---
 rtl/inst_fetch_buf_pkg.sv | 10 +
 rtl/inst_fetch_buf_tag_fifo.sv | 86 ++++++++
 rtl/inst_fetch_buf.sv | 92 +++++++++
 tb/tb_inst_fetch_buf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_buf_pkg.sv
// Shared definitions for the instruction fetch buffer: XLEN, NOP encoding, tag entry layout.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic            stale;
        logic [XLEN-1:0] addr;
    } tag_entry_t;
endpackage

// File: rtl/inst_fetch_buf_tag_fifo.sv
// In-order address-tag FIFO for outstanding fetches; stale marking only when
// INST_FETCH_FLUSH_EN is defined.
module inst_tag_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            pop,
`ifdef INST_FETCH_FLUSH_EN
    input  logic            flush,
`endif
    output tag_entry_t      head,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] addr_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (push) begin
            addr_d[wr_q] = push_addr;
            wr_d         = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            addr_q <= addr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef INST_FETCH_FLUSH_EN
    logic [DEPTH-1:0] stale_q, stale_d;

    // Marking every slot is safe: a slot only becomes live through a push,
    // which clears its mark, and pushes never coincide with a flush.
    always_comb begin
        stale_d = stale_q;
        if (flush) stale_d = '1;
        if (push) stale_d[wr_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stale_q <= '0;
        else        stale_q <= stale_d;
    end

    assign head.stale = stale_q[rd_q] | flush;
`else
    assign head.stale = 1'b0;
`endif

    assign head.addr = addr_q[rd_q];
    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch-side memory front end: issues core fetches over valid/ready, returns in-order
// responses one cycle after arrival. Optional FLUSH port via INST_FETCH_FLUSH_EN.
module inst_fetch_buf
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            INST_RDEN,
    input  logic [XLEN-1:0] INST_RIADDR,
    output logic [XLEN-1:0] INST_ROADDR,
    output logic            INST_RVALID,
    output logic [XLEN-1:0] INST_RDATA,
    output logic            MEM_WAIT,
    output logic            MEM_REQ_VALID,
    input  logic            MEM_REQ_READY,
    output logic [XLEN-1:0] MEM_REQ_ADDR,
    input  logic            MEM_RESP_VALID,
    input  logic [XLEN-1:0] MEM_RESP_DATA,
`ifdef INST_FETCH_FLUSH_EN
    input  logic            FLUSH,
`endif
    output logic            ERR
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush, full, empty, fire, pop;
    logic [CW-1:0]   count;
    tag_entry_t      head;

    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] roaddr_q, roaddr_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

`ifdef INST_FETCH_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    // Issue uses the registered full flag only, so a same-cycle pop never frees a slot.
    assign MEM_REQ_VALID = RST & INST_RDEN & ~full & ~flush;
    assign MEM_REQ_ADDR  = INST_RIADDR;
    assign fire          = MEM_REQ_VALID & MEM_REQ_READY;
    assign MEM_WAIT      = RST & INST_RDEN & ~fire;
    assign pop           = MEM_RESP_VALID & (count != '0);

    inst_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (fire),
        .push_addr (INST_RIADDR),
        .pop       (pop),
`ifdef INST_FETCH_FLUSH_EN
        .flush     (flush),
`endif
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        rvalid_d = pop & ~head.stale;
        roaddr_d = rvalid_d ? head.addr : '0;
        rdata_d  = rvalid_d ? MEM_RESP_DATA : NOP_INST;
        err_d    = err_q | (MEM_RESP_VALID & empty);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rvalid_q <= 1'b0;
            roaddr_q <= '0;
            rdata_q  <= NOP_INST;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            roaddr_q <= roaddr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign INST_RVALID = rvalid_q;
    assign INST_ROADDR = roaddr_q;
    assign INST_RDATA  = rdata_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed self-checking bench for inst_fetch_buf (DEPTH=4).
module tb_inst_fetch_buf;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INST_RDEN = 1'b0;
    logic [31:0] INST_RIADDR = '0;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        MEM_WAIT;
    logic        MEM_REQ_VALID;
    logic        MEM_REQ_READY = 1'b0;
    logic [31:0] MEM_REQ_ADDR;
    logic        MEM_RESP_VALID = 1'b0;
    logic [31:0] MEM_RESP_DATA = '0;
`ifdef INST_FETCH_FLUSH_EN
    logic        FLUSH = 1'b0;
`endif
    logic        ERR;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    inst_fetch_buf #(.DEPTH(4)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .INST_RDEN      (INST_RDEN),
        .INST_RIADDR    (INST_RIADDR),
        .INST_ROADDR    (INST_ROADDR),
        .INST_RVALID    (INST_RVALID),
        .INST_RDATA     (INST_RDATA),
        .MEM_WAIT       (MEM_WAIT),
        .MEM_REQ_VALID  (MEM_REQ_VALID),
        .MEM_REQ_READY  (MEM_REQ_READY),
        .MEM_REQ_ADDR   (MEM_REQ_ADDR),
        .MEM_RESP_VALID (MEM_RESP_VALID),
        .MEM_RESP_DATA  (MEM_RESP_DATA),
`ifdef INST_FETCH_FLUSH_EN
        .FLUSH          (FLUSH),
`endif
        .ERR            (ERR)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        INST_RDEN      = 1'b0;
        MEM_RESP_VALID = 1'b0;
        MEM_REQ_READY  = 1'b1;
    endtask

    task automatic test_reset();
        INST_RDEN = 1'b1; INST_RIADDR = 32'h50; MEM_REQ_READY = 1'b1;
        #1 RST = 1'b0;
        #1;
        checks++; if (MEM_REQ_VALID !== 1'b0) begin failures++; $display("FAIL rst_reqvalid got=%b exp=0", MEM_REQ_VALID); end
        checks++; if (MEM_WAIT !== 1'b0) begin failures++; $display("FAIL rst_wait got=%b exp=0", MEM_WAIT); end
        checks++; if (INST_RVALID !== 1'b0 || INST_RDATA !== 32'h13 || INST_ROADDR !== 32'h0 || ERR !== 1'b0)
            begin failures++; $display("FAIL rst_outputs got v=%b d=%h a=%h e=%b exp v=0 d=13 a=0 e=0", INST_RVALID, INST_RDATA, INST_ROADDR, ERR); end
        step(); step();
        RST = 1'b1;
        #1;
        checks++; if (MEM_REQ_VALID !== 1'b1) begin failures++; $display("FAIL rst_release_reqvalid got=%b exp=1", MEM_REQ_VALID); end
        step();
        INST_RIADDR = 32'h54; MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'hAAAA_0001;
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h50 || INST_RDATA !== 32'hAAAA_0001)
            begin failures++; $display("FAIL pre_rst_resp got v=%b a=%h d=%h exp v=1 a=50 d=aaaa0001", INST_RVALID, INST_ROADDR, INST_RDATA); end
        // 0x54 is now in flight; reset mid-cycle must drop it and clear outputs immediately
        MEM_RESP_VALID = 1'b0; INST_RIADDR = 32'h58;
        #1 RST = 1'b0;
        #1;
        checks++; if (INST_RVALID !== 1'b0 || INST_RDATA !== 32'h13 || INST_ROADDR !== 32'h0 || MEM_REQ_VALID !== 1'b0 || MEM_WAIT !== 1'b0)
            begin failures++; $display("FAIL async_rst got v=%b d=%h a=%h rq=%b w=%b exp 0,13,0,0,0", INST_RVALID, INST_RDATA, INST_ROADDR, MEM_REQ_VALID, MEM_WAIT); end
        step();
        RST = 1'b1; idle();
        MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'hDEAD;
        step();
        checks++; if (ERR !== 1'b1 || INST_RVALID !== 1'b0)
            begin failures++; $display("FAIL rst_drops_tags got err=%b v=%b exp err=1 v=0", ERR, INST_RVALID); end
        MEM_RESP_VALID = 1'b0;
        #1 RST = 1'b0;
        #1;
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL rst_clears_err got=%b exp=0", ERR); end
        step();
        RST = 1'b1;
        step();
    endtask

    task automatic test_basic();
        idle();
        INST_RDEN = 1'b1; INST_RIADDR = 32'h100; MEM_REQ_READY = 1'b0;
        #1;
        checks++; if (MEM_REQ_VALID !== 1'b1 || MEM_WAIT !== 1'b1 || MEM_REQ_ADDR !== 32'h100)
            begin failures++; $display("FAIL not_ready got rq=%b w=%b a=%h exp 1,1,100", MEM_REQ_VALID, MEM_WAIT, MEM_REQ_ADDR); end
        step();
        MEM_REQ_READY = 1'b1;
        #1;
        checks++; if (MEM_WAIT !== 1'b0) begin failures++; $display("FAIL fire_wait got=%b exp=0", MEM_WAIT); end
        step();
        INST_RDEN = 1'b0;
        step();
        MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0050_0093;
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h100 || INST_RDATA !== 32'h0050_0093)
            begin failures++; $display("FAIL basic_resp got v=%b a=%h d=%h exp 1,100,00500093", INST_RVALID, INST_ROADDR, INST_RDATA); end
        MEM_RESP_VALID = 1'b0;
        step();
        checks++; if (INST_RVALID !== 1'b0 || INST_ROADDR !== 32'h0 || INST_RDATA !== 32'h13)
            begin failures++; $display("FAIL basic_idle got v=%b a=%h d=%h exp 0,0,13", INST_RVALID, INST_ROADDR, INST_RDATA); end
    endtask

    task automatic test_full();
        idle();
        INST_RDEN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            INST_RIADDR = 32'(i * 4);
            #1;
            checks++; if (MEM_REQ_VALID !== 1'b1 || MEM_WAIT !== 1'b0)
                begin failures++; $display("FAIL fill_%0d got rq=%b w=%b exp 1,0", i, MEM_REQ_VALID, MEM_WAIT); end
            step();
        end
        INST_RIADDR = 32'h10;
        #1;
        checks++; if (MEM_REQ_VALID !== 1'b0 || MEM_WAIT !== 1'b1)
            begin failures++; $display("FAIL full_block got rq=%b w=%b exp 0,1", MEM_REQ_VALID, MEM_WAIT); end
        step();
        MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'hD0;
        #1;
        checks++; if (MEM_WAIT !== 1'b1) begin failures++; $display("FAIL full_pop_no_push got w=%b exp 1", MEM_WAIT); end
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h0 || INST_RDATA !== 32'hD0)
            begin failures++; $display("FAIL full_resp0 got v=%b a=%h d=%h exp 1,0,d0", INST_RVALID, INST_ROADDR, INST_RDATA); end
        MEM_RESP_VALID = 1'b0;
        #1;
        checks++; if (MEM_REQ_VALID !== 1'b1 || MEM_WAIT !== 1'b0)
            begin failures++; $display("FAIL refire got rq=%b w=%b exp 1,0", MEM_REQ_VALID, MEM_WAIT); end
        step();
        INST_RDEN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'(32'hD1 + i);
            step();
            checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'(4 * (i + 1)) || INST_RDATA !== 32'(32'hD1 + i))
                begin failures++; $display("FAIL drain_%0d got v=%b a=%h d=%h exp 1,%h,%h", i, INST_RVALID, INST_ROADDR, INST_RDATA, 4 * (i + 1), 32'hD1 + i); end
        end
        MEM_RESP_VALID = 1'b0;
        step();
        checks++; if (INST_RVALID !== 1'b0 || ERR !== 1'b0)
            begin failures++; $display("FAIL drain_end got v=%b e=%b exp 0,0", INST_RVALID, ERR); end
    endtask

    task automatic test_back_to_back();
        idle();
        INST_RDEN = 1'b1; INST_RIADDR = 32'h0;
        step();
        INST_RIADDR = 32'h4;
        step();
        INST_RIADDR = 32'h8; MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'hB0;
        #1;
        checks++; if (MEM_REQ_VALID !== 1'b1) begin failures++; $display("FAIL b2b_fire got=%b exp=1", MEM_REQ_VALID); end
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h0 || INST_RDATA !== 32'hB0)
            begin failures++; $display("FAIL b2b_0 got v=%b a=%h d=%h exp 1,0,b0", INST_RVALID, INST_ROADDR, INST_RDATA); end
        INST_RDEN = 1'b0; MEM_RESP_DATA = 32'hB1;
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h4 || INST_RDATA !== 32'hB1)
            begin failures++; $display("FAIL b2b_1 got v=%b a=%h d=%h exp 1,4,b1", INST_RVALID, INST_ROADDR, INST_RDATA); end
        MEM_RESP_DATA = 32'hB2;
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h8 || INST_RDATA !== 32'hB2)
            begin failures++; $display("FAIL b2b_2 got v=%b a=%h d=%h exp 1,8,b2", INST_RVALID, INST_ROADDR, INST_RDATA); end
        MEM_RESP_VALID = 1'b0;
        step();
        checks++; if (INST_RVALID !== 1'b0 || ERR !== 1'b0)
            begin failures++; $display("FAIL b2b_end got v=%b e=%b exp 0,0", INST_RVALID, ERR); end
    endtask

`ifdef INST_FETCH_FLUSH_EN
    task automatic test_flush();
        idle();
        INST_RDEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            INST_RIADDR = 32'(32'h20 + 4 * i);
            step();
        end
        INST_RIADDR = 32'h40; FLUSH = 1'b1; MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'hF0;
        #1;
        checks++; if (MEM_REQ_VALID !== 1'b0 || MEM_WAIT !== 1'b1)
            begin failures++; $display("FAIL flush_block got rq=%b w=%b exp 0,1", MEM_REQ_VALID, MEM_WAIT); end
        step();
        FLUSH = 1'b0; INST_RDEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (INST_RVALID !== 1'b0)
                begin failures++; $display("FAIL flush_stale_%0d got v=%b exp 0", i, INST_RVALID); end
            MEM_RESP_DATA = 32'(32'hF1 + i);
            MEM_RESP_VALID = (i < 2);
            step();
        end
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL flush_err got=%b exp=0", ERR); end
        INST_RDEN = 1'b1; INST_RIADDR = 32'h200;
        step();
        INST_RDEN = 1'b0; MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h22;
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h200 || INST_RDATA !== 32'h22)
            begin failures++; $display("FAIL post_flush got v=%b a=%h d=%h exp 1,200,22", INST_RVALID, INST_ROADDR, INST_RDATA); end
        MEM_RESP_VALID = 1'b0;
        step();
    endtask
`endif

    task automatic test_err();
        idle();
        MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'hEE;
        #1;
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL err_pre got=%b exp=0", ERR); end
        step();
        checks++; if (ERR !== 1'b1 || INST_RVALID !== 1'b0)
            begin failures++; $display("FAIL err_set got e=%b v=%b exp 1,0", ERR, INST_RVALID); end
        MEM_RESP_VALID = 1'b0;
        step();
        checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", ERR); end
        INST_RDEN = 1'b1; INST_RIADDR = 32'h300;
        step();
        INST_RDEN = 1'b0; MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h33;
        step();
        checks++; if (INST_RVALID !== 1'b1 || INST_ROADDR !== 32'h300 || INST_RDATA !== 32'h33 || ERR !== 1'b1)
            begin failures++; $display("FAIL err_then_fetch got v=%b a=%h d=%h e=%b exp 1,300,33,1", INST_RVALID, INST_ROADDR, INST_RDATA, ERR); end
        MEM_RESP_VALID = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
`ifdef INST_FETCH_FLUSH_EN
        test_flush();
`endif
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
